// File: rtl/wave_frame_reader.sv
// Reads one captured frame of NUM_POINTS samples from the wave RAM and streams it
// out on a valid/ready byte interface, pulsing ram_rd_over once the frame is consumed.
module wave_frame_reader #(
    parameter int NUM_POINTS = 300,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int INVERT     = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] wave_rd_addr,
    input  logic [7:0]        wave_rd_data,
    output logic              ram_rd_over,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = ADDR_W + 1;
    localparam logic [RC_W-1:0] NUM_PTS  = RC_W'(NUM_POINTS);
    localparam logic [RC_W-1:0] LAST_IDX = RC_W'(NUM_POINTS - 1);
    localparam logic [CNT_W:0]  DEPTH_X  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OVER} state_t;

    function automatic logic [7:0] map_sample(input logic [7:0] s);
        return (INVERT != 0) ? (8'd255 - s) : s;
    endfunction

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [RC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vld_p1_q, vld_p1_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              over_q, over_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic              issue, push, pop, final_beat;

    // Read issue counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        issue        = (state_q == READ) && (rd_cnt_q < NUM_PTS) &&
                       (({1'b0, count_q} + {{CNT_W{1'b0}}, vld_p1_q}) < DEPTH_X);
        push         = vld_p1_q;
        m_valid      = (count_q != '0);
        pop          = m_valid && m_ready;
        m_last       = m_valid && (out_cnt_q == LAST_IDX);
        m_data       = m_valid ? fifo_mem[rd_ptr_q] : 8'd0;
        final_beat   = pop && m_last;
        ram_rd_en    = issue;
        wave_rd_addr = issue ? rd_cnt_q[ADDR_W-1:0] : addr_q;
        busy         = busy_q;
        ram_rd_over  = over_q;
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        addr_d    = wave_rd_addr;
        vld_p1_d  = issue;
        wr_ptr_d  = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (issue) rd_cnt_d = rd_cnt_q + RC_W'(1);
        if (pop) out_cnt_d = out_cnt_q + RC_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            READ:    if (issue && (rd_cnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (final_beat) state_d = OVER;
            OVER:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            addr_q    <= '0;
            vld_p1_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            addr_q    <= addr_d;
            vld_p1_q  <= vld_p1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            over_q    <= over_d;
        end
    end

    // RAM data returns one cycle after the read strobe and lands straight in the FIFO.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= map_sample(wave_rd_data);
    end

    always_ff @(posedge clk) begin
        if (rstn && push && !pop) assert (count_q != CNT_W'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_wave_frame_reader.sv
// Directed bench for wave_frame_reader: normal, stalled, restart, abort and inverted frames.
module tb_wave_frame_reader;

    localparam int NP = 300;

    logic       clk = 1'b0;
    logic       rstn, start, m_ready;
    logic       busy, ram_rd_en, ram_rd_over, m_valid, m_last;
    logic [8:0] wave_rd_addr;
    logic [7:0] wave_rd_data = 8'd0;
    logic [7:0] m_data;

    logic       start_i;
    logic       busy_i, ram_rd_en_i, ram_rd_over_i, m_valid_i, m_last_i;
    logic [8:0] wave_rd_addr_i;
    logic [7:0] wave_rd_data_i = 8'd0;
    logic [7:0] m_data_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int nb, first_cyc, last_cyc, over_cnt, over_cyc, fall_cyc, start_cyc;
    int stall_err, rule_err, model_err, addr_err, last_err, busy_err, timeout;
    int beats [NP];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ram_rd_en) wave_rd_data <= wave_rd_addr[7:0];
    always @(posedge clk) if (ram_rd_en_i) wave_rd_data_i <= wave_rd_addr_i[7:0];

    wave_frame_reader #(.NUM_POINTS(NP), .ADDR_W(9), .FIFO_DEPTH(4), .INVERT(0)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .ram_rd_en(ram_rd_en),
        .wave_rd_addr(wave_rd_addr), .wave_rd_data(wave_rd_data), .ram_rd_over(ram_rd_over),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    wave_frame_reader #(.NUM_POINTS(NP), .ADDR_W(9), .FIFO_DEPTH(4), .INVERT(1)) u_inv (
        .clk(clk), .rstn(rstn), .start(start_i), .busy(busy_i), .ram_rd_en(ram_rd_en_i),
        .wave_rd_addr(wave_rd_addr_i), .wave_rd_data(wave_rd_data_i), .ram_rd_over(ram_rd_over_i),
        .m_data(m_data_i), .m_valid(m_valid_i), .m_ready(1'b1), .m_last(m_last_i)
    );

    // Drives one frame on u_dut and collects beats plus protocol statistics.
    task automatic run_frame(input int pct, input bit restart, input int stop_beat, input int max_cyc);
        int count_m, infl_prev, exp_addr;
        bit prev_stall, pulsed100, done, xfer;
        logic [7:0] pd;
        nb = 0; first_cyc = -1; last_cyc = -1; over_cnt = 0; over_cyc = -1; fall_cyc = -1;
        stall_err = 0; rule_err = 0; model_err = 0; addr_err = 0; last_err = 0; busy_err = 0;
        timeout = 0; start_cyc = -1;
        for (int i = 0; i < NP; i++) beats[i] = -1;
        count_m = 0; infl_prev = 0; exp_addr = 0; prev_stall = 0; pulsed100 = 0; done = 0; pd = 8'd0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (stop_beat >= 0 && nb >= stop_beat) begin
                start = 1'b0;
                return;
            end
            start = (i == 0);
            if (restart && nb == 100 && !pulsed100) begin start = 1'b1; pulsed100 = 1; end
            if (restart && ram_rd_over) start = 1'b1;
            m_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            #1;
            if (i == 0) start_cyc = cyc;
            if (i > 0 && !busy && over_cnt > 0) begin
                fall_cyc = cyc;
                done = 1;
                break;
            end
            if ((i == 0 && busy) || (i > 0 && !busy)) busy_err++;
            if (m_valid !== (count_m != 0)) model_err++;
            if (ram_rd_en && (count_m + infl_prev >= 4)) rule_err++;
            if (ram_rd_en) begin
                if (exp_addr >= NP || wave_rd_addr !== exp_addr[8:0]) addr_err++;
                exp_addr++;
            end
            if (prev_stall && (!m_valid || m_data !== pd)) stall_err++;
            if (m_last !== (m_valid && nb == NP - 1)) last_err++;
            xfer = m_valid && m_ready;
            if (xfer) begin
                if (nb == 0) first_cyc = cyc;
                if (nb < NP) beats[nb] = int'(m_data);
                nb++;
                last_cyc = cyc;
            end
            if (ram_rd_over) begin over_cnt++; over_cyc = cyc; end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            count_m = count_m + infl_prev - (xfer ? 1 : 0);
            infl_prev = ram_rd_en ? 1 : 0;
        end
        start = 1'b0;
        if (!done && stop_beat < 0) timeout = 1;
    endtask

    task automatic test_reset();
        int bad;
        rstn = 1'b0; start = 1'b0; start_i = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, ram_rd_en, wave_rd_addr, ram_rd_over, m_valid, m_last, m_data} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b en=%b addr=%0d over=%b vld=%b last=%b data=%0d exp all 0",
                     busy, ram_rd_en, wave_rd_addr, ram_rd_over, m_valid, m_last, m_data);
        end
        checks++;
        if ({busy_i, ram_rd_en_i, ram_rd_over_i, m_valid_i, m_data_i} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs_inv got busy=%b en=%b over=%b vld=%b data=%0d exp all 0",
                     busy_i, ram_rd_en_i, ram_rd_over_i, m_valid_i, m_data_i);
        end
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (ram_rd_en || m_valid || busy || ram_rd_over) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_quiet active_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_frame();
        int bad;
        run_frame(100, 1'b0, -1, 1000);
        bad = 0;
        for (int i = 0; i < NP; i++) if (beats[i] != (i % 256)) bad++;
        checks++; if (timeout != 0) begin failures++; $display("FAIL frame_timeout got=%0d exp=0", timeout); end
        checks++; if (nb != NP) begin failures++; $display("FAIL frame_beats got=%0d exp=%0d", nb, NP); end
        checks++; if (bad != 0) begin failures++; $display("FAIL frame_data bad_beats=%0d exp=0", bad); end
        checks++; if (beats[NP-1] != 43) begin failures++; $display("FAIL frame_last_value got=%0d exp=43", beats[NP-1]); end
        checks++; if (first_cyc - start_cyc != 3) begin failures++; $display("FAIL frame_first_latency got=%0d exp=3", first_cyc - start_cyc); end
        checks++; if (last_cyc - first_cyc != NP - 1) begin failures++; $display("FAIL frame_back_to_back span=%0d exp=%0d", last_cyc - first_cyc, NP - 1); end
        checks++; if (last_err != 0) begin failures++; $display("FAIL frame_m_last errors=%0d exp=0", last_err); end
        checks++; if (over_cnt != 1) begin failures++; $display("FAIL frame_over_count got=%0d exp=1", over_cnt); end
        checks++; if (over_cyc != last_cyc + 1) begin failures++; $display("FAIL frame_over_timing got=%0d exp=%0d", over_cyc, last_cyc + 1); end
        checks++; if (fall_cyc != over_cyc + 1) begin failures++; $display("FAIL frame_busy_fall got=%0d exp=%0d", fall_cyc, over_cyc + 1); end
        checks++; if (busy_err != 0) begin failures++; $display("FAIL frame_busy errors=%0d exp=0", busy_err); end
        checks++; if (addr_err != 0) begin failures++; $display("FAIL frame_addr_order errors=%0d exp=0", addr_err); end
        checks++; if (model_err != 0) begin failures++; $display("FAIL frame_valid_model errors=%0d exp=0", model_err); end
    endtask

    task automatic test_stall();
        int bad;
        run_frame(50, 1'b0, -1, 3000);
        bad = 0;
        for (int i = 0; i < NP; i++) if (beats[i] != (i % 256)) bad++;
        checks++; if (timeout != 0) begin failures++; $display("FAIL stall_timeout got=%0d exp=0", timeout); end
        checks++; if (nb != NP) begin failures++; $display("FAIL stall_beats got=%0d exp=%0d", nb, NP); end
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_data bad_beats=%0d exp=0", bad); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_hold errors=%0d exp=0", stall_err); end
        checks++; if (rule_err != 0) begin failures++; $display("FAIL stall_read_rule errors=%0d exp=0", rule_err); end
        checks++; if (model_err != 0) begin failures++; $display("FAIL stall_valid_model errors=%0d exp=0", model_err); end
        checks++; if (last_err != 0) begin failures++; $display("FAIL stall_m_last errors=%0d exp=0", last_err); end
        checks++; if (addr_err != 0) begin failures++; $display("FAIL stall_addr_order errors=%0d exp=0", addr_err); end
        checks++; if (over_cnt != 1) begin failures++; $display("FAIL stall_over_count got=%0d exp=1", over_cnt); end
    endtask

    task automatic test_restart_ignored();
        int bad, q;
        run_frame(100, 1'b1, -1, 1000);
        bad = 0;
        for (int i = 0; i < NP; i++) if (beats[i] != (i % 256)) bad++;
        q = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (busy || ram_rd_en || ram_rd_over || m_valid) q++;
        end
        checks++; if (nb != NP) begin failures++; $display("FAIL restart_beats got=%0d exp=%0d", nb, NP); end
        checks++; if (bad != 0) begin failures++; $display("FAIL restart_data bad_beats=%0d exp=0", bad); end
        checks++; if (over_cnt != 1) begin failures++; $display("FAIL restart_over_count got=%0d exp=1", over_cnt); end
        checks++; if (q != 0) begin failures++; $display("FAIL restart_quiet_after active_cycles=%0d exp=0", q); end
    endtask

    task automatic test_reset_abort();
        int bad, ovr;
        run_frame(100, 1'b0, 150, 1000);
        checks++; if (over_cnt != 0) begin failures++; $display("FAIL abort_early_over got=%0d exp=0", over_cnt); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, ram_rd_en, wave_rd_addr, ram_rd_over, m_valid, m_last, m_data} !== 22'd0) begin
            failures++;
            $display("FAIL abort_reset_outputs got busy=%b en=%b addr=%0d over=%b vld=%b last=%b data=%0d exp all 0",
                     busy, ram_rd_en, wave_rd_addr, ram_rd_over, m_valid, m_last, m_data);
        end
        ovr = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (ram_rd_over) ovr++;
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (ram_rd_over || busy) ovr++;
        end
        checks++; if (ovr != 0) begin failures++; $display("FAIL abort_no_over active_cycles=%0d exp=0", ovr); end
        run_frame(100, 1'b0, -1, 1000);
        bad = 0;
        for (int i = 0; i < NP; i++) if (beats[i] != (i % 256)) bad++;
        checks++; if (nb != NP) begin failures++; $display("FAIL abort_new_beats got=%0d exp=%0d", nb, NP); end
        checks++; if (bad != 0) begin failures++; $display("FAIL abort_new_data bad_beats=%0d exp=0", bad); end
        checks++; if (addr_err != 0) begin failures++; $display("FAIL abort_new_addr errors=%0d exp=0", addr_err); end
        checks++; if (over_cnt != 1) begin failures++; $display("FAIL abort_new_over got=%0d exp=1", over_cnt); end
    endtask

    task automatic test_invert();
        int binv [NP];
        int n, ovr;
        bit done;
        n = 0; ovr = 0; done = 0;
        for (int i = 0; i < NP; i++) binv[i] = -1;
        @(negedge clk);
        start_i = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (m_valid_i) begin
                if (n < NP) binv[n] = int'(m_data_i);
                n++;
            end
            if (ram_rd_over_i) ovr++;
            if (ovr > 0 && !busy_i) begin done = 1; break; end
        end
        checks++; if (!done) begin failures++; $display("FAIL invert_timeout got=0 exp=1"); end
        checks++; if (n != NP) begin failures++; $display("FAIL invert_beats got=%0d exp=%0d", n, NP); end
        checks++;
        if (binv[0] != 255 || binv[1] != 254 || binv[2] != 253) begin
            failures++;
            $display("FAIL invert_first got=%0d,%0d,%0d exp=255,254,253", binv[0], binv[1], binv[2]);
        end
        checks++; if (binv[NP-1] != 212) begin failures++; $display("FAIL invert_last got=%0d exp=212", binv[NP-1]); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_restart_ignored();
        test_reset_abort();
        test_invert();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_frame_reader.md
Name: wave_frame_reader

Overview:
- Downstream consumer of the scope capture/store stage. Runs on the RAM read clock domain.
- On a start request it reads one captured frame of NUM_POINTS 8-bit samples from the wave RAM read port and streams them out over a valid/ready byte interface, marking the last sample.
- When the whole frame has been accepted downstream, it pulses ram_rd_over so the store stage can re-arm capture.
- Output feeds the host link (UART/packetiser) or the display line renderer.

Parameters:
- NUM_POINTS, 300, samples per frame; wave_rd_addr runs 0..NUM_POINTS-1.
- ADDR_W, 9, width of wave_rd_addr; must satisfy 2^ADDR_W >= NUM_POINTS.
- FIFO_DEPTH, 4, entries in the internal output buffer (power of two, >= 2).
- INVERT, 0, when 1 each output byte is 255 - sample (screen y-axis flip).

Ports:
- clk  in  1  RAM read clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request.
- busy  out  1  high from accepted start until the ram_rd_over pulse (inclusive).
- ram_rd_en  out  1  RAM read strobe.
- wave_rd_addr  out  ADDR_W  RAM read address.
- wave_rd_data  in  8  RAM data; valid exactly 1 cycle after the ram_rd_en cycle.
- ram_rd_over  out  1  one-cycle pulse: frame fully consumed.
- m_data  out  8  output sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  high with the final sample of the frame.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - FIFO empty; read and output counters = 0.
  - busy = 0, ram_rd_en = 0, wave_rd_addr = 0, ram_rd_over = 0.
  - m_valid = 0, m_last = 0, m_data = 0.
  - Reset asserted mid-frame abandons the frame; no ram_rd_over pulse is issued.
- States:
  - IDLE: start=1 -> READ. Read counter rd_cnt = 0, output counter out_cnt = 0, busy = 1 from the next cycle.
  - READ: issue reads. When the last address is issued (rd_cnt reaches NUM_POINTS) -> DRAIN.
  - DRAIN: no new reads. When the final beat is accepted (m_valid & m_ready & m_last) -> OVER.
  - OVER: ram_rd_over = 1 for exactly one cycle, busy still 1 -> IDLE next cycle.
- start while busy is ignored. A start in the same cycle as the OVER pulse is also ignored.
- Read issue rule, per cycle in READ:
  - Issue a read iff rd_cnt < NUM_POINTS and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is 1 if a read was issued in the previous cycle, else 0.
  - On issue: ram_rd_en = 1, wave_rd_addr = rd_cnt, and rd_cnt increments. Otherwise ram_rd_en = 0.
  - wave_rd_addr holds its last value when not reading.
- Return path: the cycle after an issued read, wave_rd_data (inverted if INVERT=1) is pushed into the FIFO. Overflow is impossible by construction; assert in simulation.
- Output:
  - m_valid = FIFO not empty; m_data = FIFO head; both registered/stable while m_valid & !m_ready.
  - A beat transfers on m_valid & m_ready.
  - out_cnt increments per transfer; m_last = m_valid & (out_cnt == NUM_POINTS-1).
- Simultaneous FIFO push and pop: allowed, count unchanged.
- Throughput: with m_ready held high, one sample per cycle after start.
  - First m_valid appears 3 cycles after the start cycle: state change, read, FIFO write.
  - ram_rd_over pulses 1 cycle after the last accepted beat.
- Addresses are issued strictly in order 0..NUM_POINTS-1. Each address is read exactly once per frame; no wrap.

Test Plan:
- Reset then idle, no start -> ram_rd_en, m_valid, busy, ram_rd_over all stay 0 for 100 cycles.
- Start, m_ready=1, RAM model returns data = addr[7:0] -> 300 beats 0,1,..,255,0,..,43 on consecutive cycles; m_last only on beat 300 (value 43); ram_rd_over one cycle later; busy falls the cycle after that.
- Same frame with m_ready toggling pseudo-randomly (50%) -> identical data sequence, no loss or duplication; m_data stable while stalled; ram_rd_en never raised when fifo_count + inflight = 4.
- INVERT=1, data = addr[7:0] -> first beats 255, 254, 253; beat 300 = 212.
- Start pulsed again at beat 100 and in the OVER cycle -> both ignored; exactly one frame and one ram_rd_over.
- rstn low at beat 150 for 2 cycles, then start -> outputs return to reset values immediately; no ram_rd_over from the aborted frame; the new frame starts at address 0 and delivers all 300 beats.
